// File: rtl/bcd_to_bin_if.sv
// Handshake and data bundle between a BCD source and the bcd_to_bin converter.
interface bcd_to_bin_if #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  // Requester side: issues start with a packed BCD operand.
  modport master (
    output start, bcd_in,
    input  bin_out, busy, done, err
  );

  // Converter side: returns the binary value and status.
  modport slave (
    input  start, bcd_in,
    output bin_out, busy, done, err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double dabble: shift right, then
// subtract 3 from every BCD nibble that reads 8 or more).
module bcd_to_bin #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  bcd_to_bin_if.slave  bus
);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [SR_W-1:0]   iter_c;
  logic              bad_digit_c;
  logic              last_iter_c;

  // Flag any nibble of the incoming operand that is not a decimal digit.
  always_comb begin
    bad_digit_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit_c = 1'b1;
    end
  end

  // One conversion step: shift the whole register right, then correct each BCD nibble.
  always_comb begin
    iter_c = sr_q >> 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (iter_c[int'(BIN_W) + 4*i + 3]) begin
        iter_c[int'(BIN_W) + 4*i +: 4] = iter_c[int'(BIN_W) + 4*i +: 4] - 4'd3;
      end
    end
  end

  assign last_iter_c = (cnt_q == CNT_W'(BIN_W - 1));

  // State and datapath registers; reset aborts any conversion in progress.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = bad_digit_c ? DONE : SHIFT;
      SHIFT:   if (last_iter_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the datapath and the registered status outputs.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    err_d  = err_q;
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bad_digit_c) begin
            err_d = 1'b1;
            bin_d = '0;
          end else begin
            sr_d  = {bus.bcd_in, BIN_W'(0)};
            cnt_d = '0;
            err_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        sr_d  = iter_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter_c) bin_d = iter_c[BIN_W-1:0];
      end
      default: ;
    endcase
  end

  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
